// File: rtl/dma_burst_engine.sv
// -----------------------------------------------------------------------------
// dma_burst_engine
//
// Moves cmd_len bursts of BURST_WORDS words from an external device into data
// memory starting at cmd_addr. The data bus is owned only while BG is high,
// using a BR/BG handshake with the CPU. A burst interrupted by loss of grant is
// replayed in full once grant returns. Completion is flagged on interrupt.
//
// Ports
//   CLK        in   clock, all state changes on the rising edge
//   reset_n    in   asynchronous active-low reset
//   cmd        in   start pulse, only looked at while idle
//   cmd_addr   in   base memory address of the transfer
//   cmd_len    in   number of bursts to move (0 completes immediately)
//   BG         in   bus grant from the CPU
//   edata      in   device data for the burst selected by offset
//   BR         out  bus request
//   WRITE      out  memory write strobe, high-Z while BG=0
//   addr       out  memory address, high-Z while BG=0
//   data       out  memory write data, high-Z while BG=0
//   offset     out  burst index presented to the device
//   interrupt  out  transfer complete, held until BG is released
//   busy       out  high whenever the engine is not idle
// -----------------------------------------------------------------------------
module dma_burst_engine #(
    parameter int WORD_SIZE   = 16,
    parameter int BURST_WORDS = 4,
    parameter int LEN_W       = 4,
    parameter int MEM_LAT     = 4
) (
    input  logic                               CLK,
    input  logic                               reset_n,
    input  logic                               cmd,
    input  logic [WORD_SIZE-1:0]               cmd_addr,
    input  logic [LEN_W-1:0]                   cmd_len,
    input  logic                               BG,
    input  logic [BURST_WORDS*WORD_SIZE-1:0]   edata,
    output logic                               BR,
    output wire                                WRITE,
    output wire  [WORD_SIZE-1:0]               addr,
    output wire  [BURST_WORDS*WORD_SIZE-1:0]   data,
    output logic [LEN_W-1:0]                   offset,
    output logic                               interrupt,
    output logic                               busy
);

    localparam int                CNT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(MEM_LAT - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_XFER = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]           state;
    logic [WORD_SIZE-1:0] cur_addr;
    logic [LEN_W-1:0]     total;
    logic [CNT_W-1:0]     cnt;
    logic                 write_int;

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            cur_addr <= '0;
            total    <= '0;
            cnt      <= '0;
            offset   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd) begin
                        cur_addr <= cmd_addr;
                        total    <= cmd_len;
                        offset   <= '0;
                        state    <= (cmd_len == '0) ? S_DONE : S_REQ;
                    end
                end
                S_REQ: begin
                    if (BG) begin
                        state <= S_XFER;
                        cnt   <= '0;
                    end
                end
                S_XFER: begin
                    if (cnt == CNT_LAST) begin
                        // Completion wins over a grant lost on the same edge.
                        cur_addr <= cur_addr + WORD_SIZE'(BURST_WORDS);
                        offset   <= offset + LEN_W'(1);
                        cnt      <= '0;
                        if (offset + LEN_W'(1) == total) begin
                            state <= S_DONE;
                        end else if (!BG) begin
                            state <= S_REQ;
                        end
                    end else if (!BG) begin
                        // Abort: address and offset stay put so the burst replays whole.
                        state <= S_REQ;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    if (!BG) begin
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    always_comb begin
        BR        = (state == S_REQ) || (state == S_XFER);
        busy      = (state != S_IDLE);
        interrupt = (state == S_DONE);
        write_int = (state == S_XFER) && (cnt == '0);
    end

    // The bus belongs to the CPU unless it has granted it to us.
    assign WRITE = BG ? write_int : 1'bz;
    assign addr  = BG ? cur_addr  : {WORD_SIZE{1'bz}};
    assign data  = BG ? edata     : {(BURST_WORDS*WORD_SIZE){1'bz}};

endmodule

// File: tb/tb_dma_burst_engine.sv
// -----------------------------------------------------------------------------
// tb_dma_burst_engine
//
// Directed and randomized transfers against a transaction-level expectation:
// each burst k of a transfer must be written once at base + k*BURST_WORDS with
// the device word for offset k, plus one extra replay of a burst whose grant
// was withdrawn before it finished.
// -----------------------------------------------------------------------------
module tb_dma_burst_engine;

    localparam int WS  = 16;
    localparam int BW  = 4;
    localparam int LW  = 4;
    localparam int LAT = 4;
    localparam int DW  = BW * WS;

    logic          CLK = 1'b0;
    logic          reset_n;
    logic          cmd;
    logic [WS-1:0] cmd_addr;
    logic [LW-1:0] cmd_len;
    logic          BG;
    logic [DW-1:0] edata;
    logic          BR;
    wire           WRITE;
    wire  [WS-1:0] addr;
    wire  [DW-1:0] data;
    logic [LW-1:0] offset;
    logic          interrupt;
    logic          busy;

    logic [DW-1:0] dev_tab [16];

    int passed = 0;
    int total  = 0;

    logic [WS-1:0] w_addr [$];
    logic [DW-1:0] w_data [$];
    logic [LW-1:0] w_off  [$];

    dma_burst_engine #(
        .WORD_SIZE  (WS),
        .BURST_WORDS(BW),
        .LEN_W      (LW),
        .MEM_LAT    (LAT)
    ) dut (
        .CLK      (CLK),
        .reset_n  (reset_n),
        .cmd      (cmd),
        .cmd_addr (cmd_addr),
        .cmd_len  (cmd_len),
        .BG       (BG),
        .edata    (edata),
        .BR       (BR),
        .WRITE    (WRITE),
        .addr     (addr),
        .data     (data),
        .offset   (offset),
        .interrupt(interrupt),
        .busy     (busy)
    );

    always #5 CLK = ~CLK;

    // Device model: presents the word belonging to the requested offset.
    assign edata = dev_tab[offset];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_xfer(input logic [WS-1:0] base, input int len,
                            input int drop_b, input int drop_c, input bit dup_cmd);
        int  exp_q [$];
        int  since, nw, gap, n;
        bit  dropped, done, early;
        logic [WS-1:0] last_a;
        time t_first, t_int;

        for (int i = 0; i < 16; i++) dev_tab[i] = {$urandom, $urandom};
        for (int k = 0; k < len; k++) begin
            exp_q.push_back(k);
            if (k == drop_b && drop_c < LAT - 1) exp_q.push_back(k);
        end
        w_addr.delete(); w_data.delete(); w_off.delete();
        since = 0; nw = 0; dropped = 0; done = 0; early = 0;
        last_a = '0; t_first = 0; t_int = 0;

        @(negedge CLK);
        cmd = 1'b1; cmd_addr = base; cmd_len = LW'(len);
        @(negedge CLK);
        cmd = 1'b0; cmd_addr = WS'($urandom); cmd_len = LW'($urandom);
        chk("req_br", BR, 1);
        chk("req_busy", busy, 1);
        chk("req_offset", offset, 0);
        @(negedge CLK);
        BG = 1'b1;

        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            @(negedge CLK);
            cmd = 1'b0;
            if (interrupt) begin
                done  = 1;
                t_int = $time;
            end else begin
                if (WRITE === 1'b1) begin
                    w_addr.push_back(addr);
                    w_data.push_back(data);
                    w_off.push_back(offset);
                    since  = 0;
                    nw++;
                    last_a = addr;
                    if (nw == 1) t_first = $time;
                    if (dup_cmd && nw == 2) begin
                        cmd = 1'b1; cmd_addr = ~base; cmd_len = LW'($urandom_range(1, 15));
                    end
                end else begin
                    since++;
                end
                if (!dropped && drop_b >= 0 && nw > 0 &&
                    last_a == WS'(base + drop_b * BW) && since == drop_c) begin
                    dropped = 1;
                    BG = 1'b0;
                    @(negedge CLK);
                    cmd = 1'b0;
                    if (drop_c == LAT - 1 && drop_b + 1 == len) begin
                        chk("drop_done_int", interrupt, 1);
                        chk("drop_done_br", BR, 0);
                        chk("drop_done_offset", offset, LW'(len));
                        @(negedge CLK);
                        chk("drop_done_int_clr", interrupt, 0);
                        chk("drop_done_busy", busy, 0);
                        early = 1;
                        done  = 1;
                    end else begin
                        gap = $urandom_range(1, 3);
                        for (int g = 0; g < gap; g++) begin
                            if (g > 0) @(negedge CLK);
                            chk("gap_br", BR, 1);
                            chk("gap_offset", offset, (drop_c == LAT - 1) ? drop_b + 1 : drop_b);
                            chk("gap_no_write", (WRITE === 1'b1), 0);
                        end
                        BG = 1'b1;
                    end
                end
            end
        end

        chk("xfer_finished", done, 1);
        if (done && !early) begin
            chk("done_offset", offset, LW'(len));
            chk("done_br", BR, 0);
            if (drop_b < 0) chk("xfer_cycles", (t_int - t_first) / 10, len * LAT);
            @(negedge CLK);
            chk("int_held", interrupt, 1);
            BG = 1'b0;
            @(negedge CLK);
            chk("int_clear", interrupt, 0);
            chk("idle_busy", busy, 0);
            chk("idle_br", BR, 0);
        end
        BG = 1'b0;

        chk("write_count", w_addr.size(), exp_q.size());
        n = (w_addr.size() < exp_q.size()) ? w_addr.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk("wr_addr", w_addr[i], WS'(base + exp_q[i] * BW));
            chk("wr_data", w_data[i], dev_tab[exp_q[i]]);
            chk("wr_offset", w_off[i], exp_q[i]);
        end
    endtask

    initial begin
        bit seen;
        int len, db, dc;

        for (int i = 0; i < 16; i++) dev_tab[i] = '0;

        // Reset with random inputs applied.
        reset_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cmd = 1'($urandom); cmd_addr = WS'($urandom);
            cmd_len = LW'($urandom); BG = 1'($urandom);
            @(negedge CLK);
            chk("rst_br", BR, 0);
            chk("rst_offset", offset, 0);
            chk("rst_int", interrupt, 0);
            chk("rst_busy", busy, 0);
            chk("rst_no_write", (WRITE === 1'b1), 0);
        end
        cmd = 1'b0; BG = 1'b0;
        @(negedge CLK);
        reset_n = 1'b1;

        // Zero-length command.
        @(negedge CLK);
        cmd = 1'b1; cmd_addr = 16'h1234; cmd_len = '0;
        @(negedge CLK);
        cmd = 1'b0;
        chk("zero_br", BR, 0);
        chk("zero_int", interrupt, 1);
        chk("zero_busy", busy, 1);
        @(negedge CLK);
        chk("zero_int_clr", interrupt, 0);
        chk("zero_busy_clr", busy, 0);

        // Directed transfers.
        run_xfer(16'h01F4, 3, -1, 0, 1'b0);
        run_xfer(16'h01F4, 3, 1, 2, 1'b0);
        run_xfer(16'hFFFC, 2, -1, 0, 1'b0);
        run_xfer(16'h0100, 4, -1, 0, 1'b1);
        run_xfer(16'h0200, 2, 1, LAT - 1, 1'b0);
        run_xfer(16'h0300, 3, 0, LAT - 1, 1'b0);
        run_xfer(16'h0400, 2, 0, 0, 1'b0);

        // Randomized transfers.
        for (int r = 0; r < 6; r++) begin
            len = $urandom_range(1, 6);
            db  = ($urandom_range(0, 2) == 0) ? -1 : $urandom_range(0, len - 1);
            dc  = $urandom_range(0, LAT - 1);
            run_xfer(WS'($urandom), len, db, dc, 1'($urandom));
        end

        // Reset in the middle of a burst.
        @(negedge CLK);
        cmd = 1'b1; cmd_addr = 16'h0500; cmd_len = 4'd5;
        @(negedge CLK);
        cmd = 1'b0;
        @(negedge CLK);
        BG = 1'b1;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge CLK);
            if (WRITE === 1'b1) seen = 1;
        end
        chk("midrst_write_seen", seen, 1);
        @(negedge CLK);
        reset_n = 1'b0;
        #1;
        chk("midrst_br", BR, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_offset", offset, 0);
        chk("midrst_int", interrupt, 0);
        BG = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("postrst_br", BR, 0);
            chk("postrst_busy", busy, 0);
        end

        // Recovery after reset.
        run_xfer(16'h0600, 2, -1, 0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
